// File: rtl/gray_counter.sv
// Up/down binary counter with a registered Gray-code copy, terminal-count and wrap flags,
// and a sticky checker that flags any count step changing other than one Gray bit.
module gray_counter #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             up,
  input  logic             sat,
  input  logic             load,
  input  logic [WIDTH-1:0] load_bin,
  output logic [WIDTH-1:0] g,
  output logic [WIDTH-1:0] bin,
  output logic             tc,
  output logic             wrapped,
  output logic             err
);

  localparam logic [WIDTH-1:0] One = WIDTH'(1);

  logic [WIDTH-1:0] bin_q, bin_d;
  logic [WIDTH-1:0] g_q, g_d;
  logic             tc_q, tc_d;
  logic             wrapped_q, wrapped_d;
  logic             err_q, err_d;

  logic [WIDTH-1:0] term;
  logic [WIDTH-1:0] g_diff;
  logic             at_term;
  logic             step;
  logic             one_hot;

  always_comb begin
    term      = up ? '1 : '0;
    at_term   = (bin_q == term);
    bin_d     = bin_q;
    wrapped_d = 1'b0;
    step      = 1'b0;

    if (load) begin
      bin_d = load_bin;
    end else if (en && !(at_term && sat)) begin
      step      = 1'b1;
      bin_d     = up ? (bin_q + One) : (bin_q - One);
      wrapped_d = at_term;
    end

    // Gray code is registered alongside the binary value, not decoded at the output.
    g_d  = bin_d ^ (bin_d >> 1);
    tc_d = (bin_d == term);

    g_diff  = g_q ^ g_d;
    one_hot = (g_diff != '0) && ((g_diff & (g_diff - One)) == '0);
    err_d   = err_q | (step & ~one_hot);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bin_q     <= '0;
      g_q       <= '0;
      tc_q      <= 1'b0;
      wrapped_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      bin_q     <= bin_d;
      g_q       <= g_d;
      tc_q      <= tc_d;
      wrapped_q <= wrapped_d;
      err_q     <= err_d;
    end
  end

  assign bin     = bin_q;
  assign g       = g_q;
  assign tc      = tc_q;
  assign wrapped = wrapped_q;
  assign err     = err_q;

endmodule

// File: tb/tb_gray_counter.sv
// Directed-vector bench for gray_counter (WIDTH=4) plus a short randomized run
// against a small reference model.
module tb_gray_counter;

  localparam int unsigned W = 4;

  logic         clk;
  logic         rst_n;
  logic         en;
  logic         up;
  logic         sat;
  logic         load;
  logic [W-1:0] load_bin;
  logic [W-1:0] g;
  logic [W-1:0] bin;
  logic         tc;
  logic         wrapped;
  logic         err;

  int n_total;
  int n_bad;

  gray_counter #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .up       (up),
    .sat      (sat),
    .load     (load),
    .load_bin (load_bin),
    .g        (g),
    .bin      (bin),
    .tc       (tc),
    .wrapped  (wrapped),
    .err      (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [W-1:0] g_seq [17] = '{4'b0000, 4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0111,
                               4'b0101, 4'b0100, 4'b1100, 4'b1101, 4'b1111, 4'b1110,
                               4'b1010, 4'b1011, 4'b1001, 4'b1000, 4'b0000};

  int unsigned m_bin;
  int unsigned n_bin;
  logic        m_wrap;
  logic        m_tc;

  initial begin
    n_total  = 0;
    n_bad    = 0;
    en       = 1'b0;
    up       = 1'b0;
    sat      = 1'b0;
    load     = 1'b0;
    load_bin = '0;
    rst_n    = 1'b1;
    #1 rst_n = 1'b0;
    #11;
    check("rst_bin", 32'(bin), 0);
    check("rst_g", 32'(g), 0);
    check("rst_tc", 32'(tc), 0);
    check("rst_wrapped", 32'(wrapped), 0);
    check("rst_err", 32'(err), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Full up-count with wrap.
    en  = 1'b1;
    up  = 1'b1;
    sat = 1'b0;
    for (int i = 1; i <= 16; i++) begin
      tick();
      check($sformatf("up_g%0d", i), 32'(g), 32'(g_seq[i]));
      check($sformatf("up_bin%0d", i), 32'(bin), 32'(i % 16));
      check($sformatf("up_wrap%0d", i), 32'(wrapped), (i == 16) ? 1 : 0);
      check($sformatf("up_tc%0d", i), 32'(tc), (i == 15) ? 1 : 0);
    end
    check("up_err", 32'(err), 0);
    en = 1'b0;
    tick();
    check("hold_wrap_clr", 32'(wrapped), 0);
    check("hold_bin", 32'(bin), 0);

    // Load 5 then count down once.
    load     = 1'b1;
    load_bin = 4'd5;
    tick();
    check("ld5_bin", 32'(bin), 5);
    check("ld5_g", 32'(g), 32'(4'b0111));
    load = 1'b0;
    en   = 1'b1;
    up   = 1'b0;
    tick();
    check("dn4_bin", 32'(bin), 4);
    check("dn4_g", 32'(g), 32'(4'b0110));
    check("dn4_tc", 32'(tc), 0);

    // Direction change takes effect immediately.
    up = 1'b1;
    tick();
    check("dir_up_bin", 32'(bin), 5);
    up = 1'b0;
    tick();
    check("dir_dn_bin", 32'(bin), 4);

    // Saturate at all-ones going up.
    en       = 1'b0;
    load     = 1'b1;
    load_bin = 4'd15;
    up       = 1'b1;
    tick();
    check("ld15_tc", 32'(tc), 1);
    load = 1'b0;
    en   = 1'b1;
    sat  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("satup_bin%0d", i), 32'(bin), 15);
      check($sformatf("satup_g%0d", i), 32'(g), 32'(4'b1000));
      check($sformatf("satup_tc%0d", i), 32'(tc), 1);
      check($sformatf("satup_wrap%0d", i), 32'(wrapped), 0);
    end

    // Saturate at zero going down.
    en       = 1'b0;
    load     = 1'b1;
    load_bin = 4'd0;
    up       = 1'b0;
    tick();
    check("ld0_tc", 32'(tc), 1);
    load = 1'b0;
    en   = 1'b1;
    sat  = 1'b1;
    tick();
    check("satdn_bin", 32'(bin), 0);
    check("satdn_wrap", 32'(wrapped), 0);

    // Wrap down from zero.
    sat = 1'b0;
    tick();
    check("wrapdn_bin", 32'(bin), 15);
    check("wrapdn_g", 32'(g), 32'(4'b1000));
    check("wrapdn_wrap", 32'(wrapped), 1);
    check("wrapdn_tc", 32'(tc), 0);
    en = 1'b0;
    tick();
    check("wrapdn_wrap_clr", 32'(wrapped), 0);

    // Load beats enable, then async reset between edges.
    load     = 1'b1;
    en       = 1'b1;
    up       = 1'b1;
    load_bin = 4'd9;
    tick();
    check("ldEn_bin", 32'(bin), 9);
    check("ldEn_g", 32'(g), 32'(4'b1101));
    load = 1'b0;
    en   = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("async_bin", 32'(bin), 0);
    check("async_g", 32'(g), 0);
    check("async_tc", 32'(tc), 0);
    check("async_wrap", 32'(wrapped), 0);
    check("async_err", 32'(err), 0);
    #2 rst_n = 1'b1;

    // Randomized run against a reference model.
    m_bin = 0;
    for (int c = 0; c < 2000; c++) begin
      @(negedge clk);
      en       = ($urandom_range(0, 9) < 8);
      up       = ($urandom_range(0, 9) < 6);
      sat      = ($urandom_range(0, 3) == 0);
      load     = ($urandom_range(0, 19) == 0);
      load_bin = W'($urandom_range(0, 15));
      m_wrap   = 1'b0;
      n_bin    = m_bin;
      if (load) begin
        n_bin = int'(load_bin);
      end else if (en) begin
        if (up) begin
          if (m_bin == 15) begin
            if (!sat) begin
              n_bin  = 0;
              m_wrap = 1'b1;
            end
          end else begin
            n_bin = m_bin + 1;
          end
        end else begin
          if (m_bin == 0) begin
            if (!sat) begin
              n_bin  = 15;
              m_wrap = 1'b1;
            end
          end else begin
            n_bin = m_bin - 1;
          end
        end
      end
      m_tc  = up ? (n_bin == 15) : (n_bin == 0);
      m_bin = n_bin;
      tick();
      check("rnd_bin", 32'(bin), m_bin);
      check("rnd_g", 32'(g), m_bin ^ (m_bin >> 1));
      check("rnd_wrap", 32'(wrapped), 32'(m_wrap));
      check("rnd_tc", 32'(tc), 32'(m_tc));
      check("rnd_err", 32'(err), 0);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
